// File: rtl/sync_ram_pkg.sv
// sync_ram_pkg
//   Shared types and helpers for the multi-read-port synchronous RAM.
//   - rdw_mode_e : read-during-write policy for a read and a write to the
//                  same address on the same edge
//   - state_e    : clear sequencer states
//   - lane_parity: even parity of one write lane, zero-extended to LANE_MAX_W
package sync_ram_pkg;

  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Widest lane the parity helper accepts; narrower lanes are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int LANE_MAX_W = 64;

  function automatic logic lane_parity(input logic [LANE_MAX_W-1:0] lane_v);
    return ^lane_v;
  endfunction

endpackage

// File: rtl/sync_ram_mp_if.sv
// sync_ram_mp_if
//   Bus bundle of the multi-read-port RAM. Signal names keep the RAM's own
//   port names so the slave side reads like the original port list.
//   Write side : wr_en_i, wr_addr_i, wr_be_i, data_i
//   Read side  : rd_en_i (one per port), rd_addr_i (packed, port k at k*AW_P)
//   Results    : data_o (packed, port k at k*WIDTH_P), valid_o, parity_err_o
//   Status     : busy_o (clear sequence running)
//   master: requester side; slave: the RAM.
interface sync_ram_mp_if #(
  parameter int WIDTH_P  = 32,
  parameter int AW_P     = 7,
  parameter int NUM_RD_P = 2,
  parameter int NB_P     = 4
);
  logic                         wr_en_i;
  logic [AW_P-1:0]              wr_addr_i;
  logic [NB_P-1:0]              wr_be_i;
  logic [WIDTH_P-1:0]           data_i;
  logic [NUM_RD_P-1:0]          rd_en_i;
  logic [NUM_RD_P*AW_P-1:0]     rd_addr_i;
  logic [NUM_RD_P*WIDTH_P-1:0]  data_o;
  logic [NUM_RD_P-1:0]          valid_o;
  logic                         busy_o;
  logic [NUM_RD_P-1:0]          parity_err_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_be_i, data_i, rd_en_i, rd_addr_i,
    input  data_o, valid_o, busy_o, parity_err_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_be_i, data_i, rd_en_i, rd_addr_i,
    output data_o, valid_o, busy_o, parity_err_o
  );
endinterface

// File: rtl/sync_ram_rd_port.sv
// sync_ram_rd_port
//   One read port of sync_ram_mp. Chooses between the raw array word and the
//   same-edge write bypass word according to RDW_MODE_P, zeroes out-of-range
//   reads, registers data/valid/parity error, and optionally adds a second
//   output register (OUT_REG_P=1).
//   Ports:
//     clk_i, rstn_i          clock, async active-low reset
//     rd_en_i                accepted read request (already gated by RUN)
//     in_range_i             read address < DEPTH
//     byp_hit_i              a write to the same address lands on this edge
//     raw_data_i/raw_par_i   stored word and its lane parity bits
//     byp_data_i/byp_par_i   stored word merged with the enabled write lanes
//     data_o                 read data, holds when no new read completes
//     valid_o                one pulse per accepted read
//     parity_err_o           lane parity mismatch, only together with valid_o
module sync_ram_rd_port
  import sync_ram_pkg::*;
#(
  parameter int        WIDTH_P    = 32,
  parameter int        BYTE_W_P   = 8,
  parameter int        OUT_REG_P  = 0,
  parameter rdw_mode_e RDW_MODE_P = RDW_READ_FIRST,
  parameter int        PAR_EN_P   = 0
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          rd_en_i,
  input  logic                          in_range_i,
  input  logic                          byp_hit_i,
  input  logic [WIDTH_P-1:0]            raw_data_i,
  input  logic [WIDTH_P/BYTE_W_P-1:0]   raw_par_i,
  input  logic [WIDTH_P-1:0]            byp_data_i,
  input  logic [WIDTH_P/BYTE_W_P-1:0]   byp_par_i,
  output logic [WIDTH_P-1:0]            data_o,
  output logic                          valid_o,
  output logic                          parity_err_o
);
  localparam int NB = WIDTH_P / BYTE_W_P;

  logic [WIDTH_P-1:0] sel_data_s;
  logic [NB-1:0]      sel_par_s;
  logic               mis_s;
  logic               perr_s;
  logic [WIDTH_P-1:0] d1_r;
  logic               v1_r;
  logic               p1_r;

  // Word selection: bypass only under write-first, out-of-range forces zero.
  always_comb begin
    sel_data_s = raw_data_i;
    sel_par_s  = raw_par_i;
    if (!in_range_i) begin
      sel_data_s = '0;
      sel_par_s  = '0;
    end else if ((RDW_MODE_P == RDW_WRITE_FIRST) && byp_hit_i) begin
      sel_data_s = byp_data_i;
      sel_par_s  = byp_par_i;
    end else begin
      sel_data_s = raw_data_i;
      sel_par_s  = raw_par_i;
    end
  end

  // Recompute lane parity of the selected word and compare with stored bits.
  always_comb begin
    mis_s = 1'b0;
    for (int j = 0; j < NB; j++) begin
      mis_s = mis_s |
              (lane_parity(LANE_MAX_W'(sel_data_s[j*BYTE_W_P +: BYTE_W_P])) ^ sel_par_s[j]);
    end
    perr_s = (PAR_EN_P != 0) ? mis_s : 1'b0;
  end

  // First output stage: valid/error pulse per request, data held otherwise.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      d1_r <= '0;
      v1_r <= 1'b0;
      p1_r <= 1'b0;
    end else begin
      v1_r <= rd_en_i;
      p1_r <= rd_en_i & perr_s;
      if (rd_en_i) begin
        d1_r <= sel_data_s;
      end else begin
        d1_r <= d1_r;
      end
    end
  end

  if (OUT_REG_P != 0) begin : g_oreg
    logic [WIDTH_P-1:0] d2_r;
    logic               v2_r;
    logic               p2_r;

    // Optional second stage: delays the pulse one cycle, data follows valid.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        d2_r <= '0;
        v2_r <= 1'b0;
        p2_r <= 1'b0;
      end else begin
        v2_r <= v1_r;
        p2_r <= p1_r;
        if (v1_r) begin
          d2_r <= d1_r;
        end else begin
          d2_r <= d2_r;
        end
      end
    end

    assign data_o       = d2_r;
    assign valid_o      = v2_r;
    assign parity_err_o = p2_r;
  end else begin : g_noreg
    assign data_o       = d1_r;
    assign valid_o      = v1_r;
    assign parity_err_o = p1_r;
  end

endmodule

// File: rtl/sync_ram_mp.sv
// sync_ram_mp
//   Multi-read-port synchronous RAM with byte-lane writes, selectable
//   read-during-write policy, optional output register and a clear sequencer
//   that zeroes every word after reset.
//   Ports:
//     clk_i   clock, all state on the rising edge
//     rstn_i  asynchronous active-low reset
//     bus     sync_ram_mp_if.slave: write port, NUM_RD_P read ports,
//             per-port data/valid/parity error, busy status
//   Optional feature: define SYNC_RAM_PARITY_EN to store one even-parity bit
//   per lane and flag mismatches on read; otherwise parity_err_o is 0.
module sync_ram_mp
  import sync_ram_pkg::*;
#(
  parameter int        WIDTH_P        = 32,
  parameter int        DEPTH_P        = 128,
  parameter int        NUM_RD_P       = 2,
  parameter int        BYTE_W_P       = 8,
  parameter int        OUT_REG_P      = 0,
  parameter rdw_mode_e RDW_MODE_P     = RDW_READ_FIRST,
  parameter int        CLEAR_ON_RST_P = 1
) (
  input logic          clk_i,
  input logic          rstn_i,
  sync_ram_mp_if.slave bus
);
  localparam int AW = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
  localparam int NB = WIDTH_P / BYTE_W_P;
`ifdef SYNC_RAM_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam state_e RST_STATE = (CLEAR_ON_RST_P != 0) ? ST_CLEAR : ST_RUN;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_P - 1);

  state_e             state_r;
  state_e             state_s;
  logic [AW-1:0]      clr_cnt_r;
  logic               run_s;
  logic               wr_ok_s;
  logic [WIDTH_P-1:0] mem_r [DEPTH_P];
`ifdef SYNC_RAM_PARITY_EN
  logic [NB-1:0]      par_r [DEPTH_P];
`endif

  assign run_s       = (state_r == ST_RUN);
  assign wr_ok_s     = run_s & bus.wr_en_i & (32'(bus.wr_addr_i) < 32'(DEPTH_P));
  assign bus.busy_o  = (state_r == ST_CLEAR);

  // Next state: CLEAR ends after the last word is zeroed, RUN is terminal.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == LAST_ADDR) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_RUN:  state_s = ST_RUN;
      default: state_s = RST_STATE;
    endcase
  end

  // State register and clear address counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r   <= RST_STATE;
      clr_cnt_r <= '0;
    end else begin
      state_r <= state_s;
      if ((state_r == ST_CLEAR) && (clr_cnt_r != LAST_ADDR)) begin
        clr_cnt_r <= clr_cnt_r + AW'(1);
      end else begin
        clr_cnt_r <= clr_cnt_r;
      end
    end
  end

  // Storage: one zero word per cycle during CLEAR, lane-masked writes in RUN.
  always_ff @(posedge clk_i) begin
    if (state_r == ST_CLEAR) begin
      mem_r[clr_cnt_r] <= '0;
`ifdef SYNC_RAM_PARITY_EN
      par_r[clr_cnt_r] <= '0;
`endif
    end else if (wr_ok_s) begin
      for (int j = 0; j < NB; j++) begin
        if (bus.wr_be_i[j]) begin
          mem_r[bus.wr_addr_i][j*BYTE_W_P +: BYTE_W_P] <= bus.data_i[j*BYTE_W_P +: BYTE_W_P];
`ifdef SYNC_RAM_PARITY_EN
          par_r[bus.wr_addr_i][j] <=
            lane_parity(LANE_MAX_W'(bus.data_i[j*BYTE_W_P +: BYTE_W_P]));
`endif
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD_P; k++) begin : g_rd
    logic [AW-1:0]      addr_s;
    logic               in_range_s;
    logic               hit_s;
    logic [WIDTH_P-1:0] raw_s;
    logic [NB-1:0]      raw_par_s;
    logic [WIDTH_P-1:0] byp_s;
    logic [NB-1:0]      byp_par_s;
    logic [WIDTH_P-1:0] dout_s;
    logic               vout_s;
    logic               perr_s;

    assign addr_s     = bus.rd_addr_i[k*AW +: AW];
    assign in_range_s = (32'(addr_s) < 32'(DEPTH_P));
    assign hit_s      = wr_ok_s & (bus.wr_addr_i == addr_s);

    // Raw stored word; the index is only used when it is inside the array.
    always_comb begin
      raw_s     = '0;
      raw_par_s = '0;
      if (in_range_s) begin
        raw_s = mem_r[addr_s];
`ifdef SYNC_RAM_PARITY_EN
        raw_par_s = par_r[addr_s];
`endif
      end else begin
        raw_s     = '0;
        raw_par_s = '0;
      end
    end

    // Bypass word: what the array will hold after this edge's write.
    always_comb begin
      byp_s     = raw_s;
      byp_par_s = raw_par_s;
      for (int j = 0; j < NB; j++) begin
        if (bus.wr_be_i[j]) begin
          byp_s[j*BYTE_W_P +: BYTE_W_P] = bus.data_i[j*BYTE_W_P +: BYTE_W_P];
          byp_par_s[j] = lane_parity(LANE_MAX_W'(bus.data_i[j*BYTE_W_P +: BYTE_W_P]));
        end else begin
          byp_s[j*BYTE_W_P +: BYTE_W_P] = raw_s[j*BYTE_W_P +: BYTE_W_P];
          byp_par_s[j] = raw_par_s[j];
        end
      end
    end

    sync_ram_rd_port #(
      .WIDTH_P    (WIDTH_P),
      .BYTE_W_P   (BYTE_W_P),
      .OUT_REG_P  (OUT_REG_P),
      .RDW_MODE_P (RDW_MODE_P),
      .PAR_EN_P   (PAR_EN)
    ) u_rd_port (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .rd_en_i      (bus.rd_en_i[k] & run_s),
      .in_range_i   (in_range_s),
      .byp_hit_i    (hit_s),
      .raw_data_i   (raw_s),
      .raw_par_i    (raw_par_s),
      .byp_data_i   (byp_s),
      .byp_par_i    (byp_par_s),
      .data_o       (dout_s),
      .valid_o      (vout_s),
      .parity_err_o (perr_s)
    );

    assign bus.data_o[k*WIDTH_P +: WIDTH_P] = dout_s;
    assign bus.valid_o[k]                   = vout_s;
    assign bus.parity_err_o[k]              = perr_s;
  end

endmodule

// File: tb/tb_sync_ram_mp.sv
// tb_sync_ram_mp
//   Directed bench for sync_ram_mp. Two instances share clock and reset:
//   dut_a: DEPTH 128, latency 1, read-first; dut_b: DEPTH 100, latency 2,
//   write-first. Inputs change on the falling edge, outputs are sampled there.
module tb_sync_ram_mp;
  import sync_ram_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sync_ram_mp_if #(.WIDTH_P(32), .AW_P(7), .NUM_RD_P(2), .NB_P(4)) if_a ();
  sync_ram_mp_if #(.WIDTH_P(32), .AW_P(7), .NUM_RD_P(2), .NB_P(4)) if_b ();

  sync_ram_mp #(
    .WIDTH_P(32), .DEPTH_P(128), .NUM_RD_P(2), .BYTE_W_P(8),
    .OUT_REG_P(0), .RDW_MODE_P(RDW_READ_FIRST), .CLEAR_ON_RST_P(1)
  ) dut_a (.clk_i(clk), .rstn_i(rstn), .bus(if_a));

  sync_ram_mp #(
    .WIDTH_P(32), .DEPTH_P(100), .NUM_RD_P(2), .BYTE_W_P(8),
    .OUT_REG_P(1), .RDW_MODE_P(RDW_WRITE_FIRST), .CLEAR_ON_RST_P(1)
  ) dut_b (.clk_i(clk), .rstn_i(rstn), .bus(if_b));

  task automatic idle_all();
    if_a.wr_en_i = 1'b0; if_a.wr_addr_i = 7'd0; if_a.wr_be_i = 4'h0; if_a.data_i = 32'h0;
    if_a.rd_en_i = 2'b00; if_a.rd_addr_i = 14'd0;
    if_b.wr_en_i = 1'b0; if_b.wr_addr_i = 7'd0; if_b.wr_be_i = 4'h0; if_b.data_i = 32'h0;
    if_b.rd_en_i = 2'b00; if_b.rd_addr_i = 14'd0;
  endtask

  // Called right after a falling edge; returns right after a falling edge.
  task automatic write_word(input bit on_b, input logic [6:0] addr,
                            input logic [3:0] be, input logic [31:0] d);
    if (on_b) begin
      if_b.wr_en_i = 1'b1; if_b.wr_addr_i = addr; if_b.wr_be_i = be; if_b.data_i = d;
    end else begin
      if_a.wr_en_i = 1'b1; if_a.wr_addr_i = addr; if_a.wr_be_i = be; if_a.data_i = d;
    end
    @(negedge clk);
    if_a.wr_en_i = 1'b0;
    if_b.wr_en_i = 1'b0;
  endtask

  // Runs right after reset release; dut_a gets requests that must be ignored.
  task automatic wait_clear(input int exp_a, input int exp_b, input string tag);
    int cnt, low_a, low_b;
    logic seen_valid;
    cnt = 0; low_a = 0; low_b = 0; seen_valid = 1'b0;
    if_a.rd_en_i = 2'b11; if_a.rd_addr_i = {7'd5, 7'd5};
    if_a.wr_en_i = 1'b1; if_a.wr_addr_i = 7'd5; if_a.wr_be_i = 4'hF; if_a.data_i = 32'hFFFF_FFFF;
    while ((low_a == 0 || low_b == 0) && cnt < 1000) begin
      @(negedge clk);
      cnt++;
      if (if_a.valid_o !== 2'b00) seen_valid = 1'b1;
      if (low_a == 0 && if_a.busy_o === 1'b0) begin
        low_a = cnt;
        if_a.rd_en_i = 2'b00;
        if_a.wr_en_i = 1'b0;
      end
      if (low_b == 0 && if_b.busy_o === 1'b0) low_b = cnt;
    end
    if_a.rd_en_i = 2'b00;
    if_a.wr_en_i = 1'b0;
    checks++;
    if (low_a != exp_a) begin
      errors++;
      $display("FAIL %s busy_a_cycles: got %0d expected %0d", tag, low_a, exp_a);
    end
    checks++;
    if (low_b != exp_b) begin
      errors++;
      $display("FAIL %s busy_b_cycles: got %0d expected %0d", tag, low_b, exp_b);
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_during_clear: got 1 expected 0", tag);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({if_a.data_o, if_a.valid_o, if_a.parity_err_o, if_a.busy_o} !== {64'h0, 2'b00, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL reset_a: got data=%h valid=%b perr=%b busy=%b expected 0/00/00/1",
               if_a.data_o, if_a.valid_o, if_a.parity_err_o, if_a.busy_o);
    end
    checks++;
    if ({if_b.data_o, if_b.valid_o, if_b.parity_err_o, if_b.busy_o} !== {64'h0, 2'b00, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL reset_b: got data=%h valid=%b perr=%b busy=%b expected 0/00/00/1",
               if_b.data_o, if_b.valid_o, if_b.parity_err_o, if_b.busy_o);
    end
    rstn = 1'b1;
    wait_clear(128, 100, "initial");
  endtask

  task automatic test_clear_zero();
    for (int i = 0; i < 128; i++) begin
      if_a.rd_en_i   = 2'b11;
      if_a.rd_addr_i = {7'(127 - i), 7'(i)};
      @(negedge clk);
      checks++;
      if ({if_a.valid_o, if_a.data_o} !== {2'b11, 64'h0}) begin
        errors++;
        $display("FAIL clear_zero addr %0d: got valid=%b data=%h expected 11/0",
                 i, if_a.valid_o, if_a.data_o);
      end
    end
    if_a.rd_en_i = 2'b00;
  endtask

  task automatic test_byte_enable();
    write_word(1'b0, 7'd5, 4'hF, 32'hDEAD_BEEF);
    write_word(1'b0, 7'd5, 4'b0010, 32'h0000_1100);
    write_word(1'b0, 7'd5, 4'b0000, 32'h0000_0000);
    write_word(1'b1, 7'd5, 4'hF, 32'hDEAD_BEEF);
    write_word(1'b1, 7'd5, 4'b0010, 32'h0000_1100);
    write_word(1'b1, 7'd5, 4'b0000, 32'h0000_0000);
    // dut_a, port 1, latency 1
    if_a.rd_en_i = 2'b10; if_a.rd_addr_i = {7'd5, 7'd0};
    @(negedge clk);
    if_a.rd_en_i = 2'b00;
    checks++;
    if ({if_a.valid_o, if_a.parity_err_o, if_a.data_o[63:32]} !== {2'b10, 2'b00, 32'hDEAD_11EF}) begin
      errors++;
      $display("FAIL be_a_read: got valid=%b perr=%b data=%h expected 10/00/dead11ef",
               if_a.valid_o, if_a.parity_err_o, if_a.data_o[63:32]);
    end
    @(negedge clk);
    checks++;
    if ({if_a.valid_o, if_a.data_o[63:32]} !== {2'b00, 32'hDEAD_11EF}) begin
      errors++;
      $display("FAIL be_a_hold: got valid=%b data=%h expected 00/dead11ef",
               if_a.valid_o, if_a.data_o[63:32]);
    end
    // dut_b, port 0, latency 2
    if_b.rd_en_i = 2'b01; if_b.rd_addr_i = {7'd0, 7'd5};
    @(negedge clk);
    if_b.rd_en_i = 2'b00;
    checks++;
    if (if_b.valid_o !== 2'b00) begin
      errors++;
      $display("FAIL be_b_early: got valid=%b expected 00", if_b.valid_o);
    end
    @(negedge clk);
    checks++;
    if ({if_b.valid_o, if_b.parity_err_o, if_b.data_o[31:0]} !== {2'b01, 2'b00, 32'hDEAD_11EF}) begin
      errors++;
      $display("FAIL be_b_read: got valid=%b perr=%b data=%h expected 01/00/dead11ef",
               if_b.valid_o, if_b.parity_err_o, if_b.data_o[31:0]);
    end
  endtask

  task automatic test_rdw();
    logic [31:0] exp_a [2];
    logic [31:0] exp_b [2];
    logic [3:0]  be_v  [2];
    logic [31:0] d_v   [2];
    exp_a[0] = 32'h0000_0000; exp_a[1] = 32'hA5A5_A5A5;
    exp_b[0] = 32'hA5A5_A5A5; exp_b[1] = 32'hA5A5_A53C;
    be_v[0]  = 4'hF;          be_v[1]  = 4'b0001;
    d_v[0]   = 32'hA5A5_A5A5; d_v[1]   = 32'h0000_003C;
    for (int s = 0; s < 2; s++) begin
      if_a.wr_en_i = 1'b1; if_a.wr_addr_i = 7'd9; if_a.wr_be_i = be_v[s]; if_a.data_i = d_v[s];
      if_a.rd_en_i = 2'b01; if_a.rd_addr_i = {7'd0, 7'd9};
      if_b.wr_en_i = 1'b1; if_b.wr_addr_i = 7'd9; if_b.wr_be_i = be_v[s]; if_b.data_i = d_v[s];
      if_b.rd_en_i = 2'b01; if_b.rd_addr_i = {7'd0, 7'd9};
      @(negedge clk);
      if_a.wr_en_i = 1'b0; if_a.rd_en_i = 2'b00;
      if_b.wr_en_i = 1'b0; if_b.rd_en_i = 2'b00;
      checks++;
      if ({if_a.valid_o, if_a.data_o[31:0]} !== {2'b01, exp_a[s]}) begin
        errors++;
        $display("FAIL rdw_read_first step %0d: got valid=%b data=%h expected 01/%h",
                 s, if_a.valid_o, if_a.data_o[31:0], exp_a[s]);
      end
      @(negedge clk);
      checks++;
      if ({if_b.valid_o, if_b.data_o[31:0]} !== {2'b01, exp_b[s]}) begin
        errors++;
        $display("FAIL rdw_write_first step %0d: got valid=%b data=%h expected 01/%h",
                 s, if_b.valid_o, if_b.data_o[31:0], exp_b[s]);
      end
    end
  endtask

  task automatic test_out_of_range();
    write_word(1'b1, 7'd120, 4'hF, 32'h1234_5678);
    if_b.rd_en_i = 2'b11; if_b.rd_addr_i = {7'd5, 7'd120};
    @(negedge clk);
    if_b.rd_en_i = 2'b00;
    @(negedge clk);
    checks++;
    if ({if_b.valid_o, if_b.parity_err_o, if_b.data_o} !== {2'b11, 2'b00, 32'hDEAD_11EF, 32'h0}) begin
      errors++;
      $display("FAIL oor_read: got valid=%b perr=%b data=%h expected 11/00/dead11ef00000000",
               if_b.valid_o, if_b.parity_err_o, if_b.data_o);
    end
    if_b.rd_en_i = 2'b01; if_b.rd_addr_i = {7'd0, 7'd20};
    @(negedge clk);
    if_b.rd_en_i = 2'b00;
    @(negedge clk);
    checks++;
    if ({if_b.valid_o, if_b.data_o} !== {2'b01, 32'hDEAD_11EF, 32'h0}) begin
      errors++;
      $display("FAIL oor_alias_word20: got valid=%b data=%h expected 01/dead11ef00000000",
               if_b.valid_o, if_b.data_o);
    end
  endtask

  task automatic test_back_to_back();
    int cnt0, cnt1;
    cnt0 = 0; cnt1 = 0;
    write_word(1'b1, 7'd3, 4'hF, 32'h0BAD_F00D);
    for (int i = 0; i < 14; i++) begin
      if_b.rd_en_i   = (i < 10) ? 2'b11 : 2'b00;
      if_b.rd_addr_i = {7'd3, 7'd3};
      @(negedge clk);
      if (if_b.valid_o[0] === 1'b1) cnt0++;
      if (if_b.valid_o[1] === 1'b1) cnt1++;
      if (if_b.valid_o !== 2'b00) begin
        checks++;
        if ({if_b.valid_o, if_b.data_o} !== {2'b11, 32'h0BAD_F00D, 32'h0BAD_F00D}) begin
          errors++;
          $display("FAIL b2b_data cycle %0d: got valid=%b data=%h expected 11/0badf00d0badf00d",
                   i, if_b.valid_o, if_b.data_o);
        end
      end
    end
    checks++;
    if (cnt0 != 10 || cnt1 != 10) begin
      errors++;
      $display("FAIL b2b_count: got %0d/%0d expected 10/10", cnt0, cnt1);
    end
  endtask

  task automatic test_reset_mid();
    if_a.rd_en_i = 2'b11; if_a.rd_addr_i = {7'd5, 7'd5};
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({if_a.valid_o, if_a.data_o} !== {2'b11, 32'hDEAD_11EF, 32'hDEAD_11EF}) begin
      errors++;
      $display("FAIL mid_pre: got valid=%b data=%h expected 11/dead11efdead11ef",
               if_a.valid_o, if_a.data_o);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({if_a.valid_o, if_a.data_o, if_a.busy_o, if_b.valid_o, if_b.busy_o} !==
        {2'b00, 64'h0, 1'b1, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset: got va=%b da=%h ba=%b vb=%b bb=%b expected 00/0/1/00/1",
               if_a.valid_o, if_a.data_o, if_a.busy_o, if_b.valid_o, if_b.busy_o);
    end
    @(negedge clk);
    rstn = 1'b1;
    wait_clear(128, 100, "after_mid_reset");
    if_a.rd_en_i = 2'b11; if_a.rd_addr_i = {7'd9, 7'd5};
    if_b.rd_en_i = 2'b11; if_b.rd_addr_i = {7'd9, 7'd5};
    @(negedge clk);
    if_a.rd_en_i = 2'b00; if_b.rd_en_i = 2'b00;
    checks++;
    if ({if_a.valid_o, if_a.data_o} !== {2'b11, 64'h0}) begin
      errors++;
      $display("FAIL mid_rezero_a: got valid=%b data=%h expected 11/0", if_a.valid_o, if_a.data_o);
    end
    @(negedge clk);
    checks++;
    if ({if_b.valid_o, if_b.data_o} !== {2'b11, 64'h0}) begin
      errors++;
      $display("FAIL mid_rezero_b: got valid=%b data=%h expected 11/0", if_b.valid_o, if_b.data_o);
    end
  endtask

`ifdef SYNC_RAM_PARITY_EN
  task automatic test_parity();
    write_word(1'b0, 7'd7, 4'hF, 32'h1234_5678);
    if_a.rd_en_i = 2'b01; if_a.rd_addr_i = {7'd0, 7'd7};
    @(negedge clk);
    if_a.rd_en_i = 2'b00;
    checks++;
    if ({if_a.valid_o, if_a.parity_err_o} !== {2'b01, 2'b00}) begin
      errors++;
      $display("FAIL parity_clean: got valid=%b perr=%b expected 01/00", if_a.valid_o, if_a.parity_err_o);
    end
    dut_a.mem_r[7][0] = ~dut_a.mem_r[7][0];
    if_a.rd_en_i = 2'b01;
    @(negedge clk);
    if_a.rd_en_i = 2'b00;
    checks++;
    if ({if_a.valid_o, if_a.parity_err_o, if_a.data_o[31:0]} !== {2'b01, 2'b01, 32'h1234_5679}) begin
      errors++;
      $display("FAIL parity_flip: got valid=%b perr=%b data=%h expected 01/01/12345679",
               if_a.valid_o, if_a.parity_err_o, if_a.data_o[31:0]);
    end
  endtask
`endif

  initial begin
    idle_all();
    test_reset();
    test_clear_zero();
    test_byte_enable();
    test_rdw();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
`ifdef SYNC_RAM_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
